// File: rtl/gate_vector_sweeper.sv
// Clocked sweep of all 16 {M,A,B,C} vectors through a four-output gate bank,
// checking each sampled response against the golden gate equations.
module gate_vector_sweeper #(
    parameter int HOLD_CYCLES = 2,
    parameter int CNT_W       = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             vec_m,
    output logic             vec_a,
    output logic             vec_b,
    output logic             vec_c,
    input  logic             p1,
    input  logic             p2,
    input  logic             p3,
    input  logic             p4,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_seen,
    output logic [3:0]       first_err_idx
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [7:0]       hold_q, hold_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             err_seen_q, err_seen_d;
    logic [3:0]       first_q, first_d;
    logic             mismatch;

    // Expected {P1,P2,P3,P4} for vector {M,A,B,C}.
    function automatic logic [3:0] golden(input logic [3:0] v);
        logic m, a, b, c, e1, e2;
        {m, a, b, c} = v;
        e1 = ~(a & b & c);
        e2 = ~((a & b) | (a & c) | (b & c));
        return {e1, e2, (m ? 1'b0 : e1), (m ? e2 : e1)};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (c == {CNT_W{1'b1}}) begin
            return c;
        end
        return c + CNT_W'(1);
    endfunction

    assign mismatch = ({p1, p2, p3, p4} != golden(idx_q));

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        hold_d     = hold_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_cnt_d  = err_cnt_q;
        err_seen_d = err_seen_q;
        first_d    = first_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = DRIVE;
                    idx_d      = 4'd0;
                    hold_d     = 8'd0;
                    busy_d     = 1'b1;
                    err_cnt_d  = '0;
                    err_seen_d = 1'b0;
                    first_d    = 4'd0;
                end
            end
            DRIVE: begin
                if (hold_q == HOLD_LAST) begin
                    if (mismatch) begin
                        err_cnt_d = sat_inc(err_cnt_q);
                        if (!err_seen_q) begin
                            err_seen_d = 1'b1;
                            first_d    = idx_q;
                        end
                    end
                    hold_d = 8'd0;
                    if (idx_q == 4'hF) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= 4'd0;
            hold_q     <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_cnt_q  <= '0;
            err_seen_q <= 1'b0;
            first_q    <= 4'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            hold_q     <= hold_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_cnt_q  <= err_cnt_d;
            err_seen_q <= err_seen_d;
            first_q    <= first_d;
        end
    end

    // The vector index doubles as the drive, so the last vector persists after a sweep.
    assign {vec_m, vec_a, vec_b, vec_c} = idx_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err_cnt       = err_cnt_q;
    assign err_seen      = err_seen_q;
    assign first_err_idx = first_q;

endmodule

// File: tb/tb_gate_vector_sweeper.sv
// Directed bench for gate_vector_sweeper: three instances cover the default,
// narrow-counter and single-cycle-hold configurations around a gate-bank model.
module tb_gate_vector_sweeper;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] sel = 2'd0;
    int         fault = 0;

    int n_checks = 0;
    int n_fail   = 0;

    int busy_n, done_n, done_at, seq_bad;

    always #5 clk = ~clk;

    // Gate bank with optional faults: 1 = P3 stuck at 1, 2 = P4 inverted.
    function automatic logic [3:0] bank(input logic [3:0] v, input int f);
        logic m, a, b, c, e1, e2;
        logic [3:0] e;
        {m, a, b, c} = v;
        e1 = ~(a & b & c);
        e2 = ~((a & b) | (a & c) | (b & c));
        e  = {e1, e2, (m ? 1'b0 : e1), (m ? e2 : e1)};
        if (f == 1) e[1] = 1'b1;
        if (f == 2) e[0] = ~e[0];
        return e;
    endfunction

    logic       st0, st1, st2;
    logic       vm0, va0, vb0, vc0, vm1, va1, vb1, vc1, vm2, va2, vb2, vc2;
    logic [3:0] pv0, pv1, pv2;
    logic       busy0, busy1, busy2, done0, done1, done2;
    logic       seen0, seen1, seen2;
    logic [4:0] cnt0, cnt2;
    logic [2:0] cnt1;
    logic [3:0] fi0, fi1, fi2;

    assign st0 = start & (sel == 2'd0);
    assign st1 = start & (sel == 2'd1);
    assign st2 = start & (sel == 2'd2);
    assign pv0 = bank({vm0, va0, vb0, vc0}, fault);
    assign pv1 = bank({vm1, va1, vb1, vc1}, fault);
    assign pv2 = bank({vm2, va2, vb2, vc2}, fault);

    gate_vector_sweeper #(.HOLD_CYCLES(2), .CNT_W(5)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(st0),
        .vec_m(vm0), .vec_a(va0), .vec_b(vb0), .vec_c(vc0),
        .p1(pv0[3]), .p2(pv0[2]), .p3(pv0[1]), .p4(pv0[0]),
        .busy(busy0), .done(done0), .err_cnt(cnt0), .err_seen(seen0), .first_err_idx(fi0)
    );

    gate_vector_sweeper #(.HOLD_CYCLES(2), .CNT_W(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(st1),
        .vec_m(vm1), .vec_a(va1), .vec_b(vb1), .vec_c(vc1),
        .p1(pv1[3]), .p2(pv1[2]), .p3(pv1[1]), .p4(pv1[0]),
        .busy(busy1), .done(done1), .err_cnt(cnt1), .err_seen(seen1), .first_err_idx(fi1)
    );

    gate_vector_sweeper #(.HOLD_CYCLES(1), .CNT_W(5)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(st2),
        .vec_m(vm2), .vec_a(va2), .vec_b(vb2), .vec_c(vc2),
        .p1(pv2[3]), .p2(pv2[2]), .p3(pv2[1]), .p4(pv2[0]),
        .busy(busy2), .done(done2), .err_cnt(cnt2), .err_seen(seen2), .first_err_idx(fi2)
    );

    logic [3:0] o_vec, o_fi;
    logic       o_busy, o_done, o_seen;
    logic [4:0] o_cnt;

    always_comb begin
        o_vec  = {vm0, va0, vb0, vc0};
        o_busy = busy0;
        o_done = done0;
        o_cnt  = cnt0;
        o_seen = seen0;
        o_fi   = fi0;
        case (sel)
            2'd1: begin
                o_vec = {vm1, va1, vb1, vc1}; o_busy = busy1; o_done = done1;
                o_cnt = {2'b00, cnt1}; o_seen = seen1; o_fi = fi1;
            end
            2'd2: begin
                o_vec = {vm2, va2, vb2, vc2}; o_busy = busy2; o_done = done2;
                o_cnt = cnt2; o_seen = seen2; o_fi = fi2;
            end
            default: ;
        endcase
    end

    // Pulses start on the selected instance and records busy/done/vector activity.
    // mode 0: plain; 1: extra start pulses at vector 6 and in the DONE cycle;
    // mode 2: P4 corrupted on every non-sample hold cycle.
    task automatic run_sweep(input int hc, input int mode);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_n = 0; done_n = 0; done_at = -1; seq_bad = 0;
        for (int k = 0; k < 16 * hc + 8; k++) begin
            if (o_busy) begin
                busy_n++;
                if (k < 16 * hc && o_vec != 4'(k / hc)) seq_bad++;
            end
            if (o_done) begin
                done_n++;
                if (done_at < 0) done_at = k;
            end
            if (mode == 1) begin
                if (k == 6 * hc || k == 16 * hc) start = 1'b1;
                else start = 1'b0;
            end
            if (mode == 2) fault = (k % 2 == 0) ? 2 : 0;
            @(posedge clk); #1;
        end
        start = 1'b0;
        fault = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            n_checks++;
            if ({o_busy, o_done, o_vec, o_cnt, o_seen, o_fi} !== 16'd0) begin
                n_fail++;
                $display("FAIL reset_outputs inst%0d: got busy=%b done=%b vec=%h cnt=%0d seen=%b fidx=%h, expected all 0",
                         s, o_busy, o_done, o_vec, o_cnt, o_seen, o_fi);
            end
        end
        sel = 2'd0;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_p3_stuck();
        sel = 2'd0; fault = 1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
        end
        fault = 0;
        n_checks++;
        if (o_cnt !== 5'd9) begin
            n_fail++; $display("FAIL p3_stuck_err_cnt: got %0d expected 9", o_cnt);
        end
        n_checks++;
        if (o_fi !== 4'h7) begin
            n_fail++; $display("FAIL p3_stuck_first_idx: got %h expected 7", o_fi);
        end
        n_checks++;
        if (o_seen !== 1'b1) begin
            n_fail++; $display("FAIL p3_stuck_err_seen: got %b expected 1", o_seen);
        end
        n_checks++;
        if (o_vec !== 4'hF) begin
            n_fail++; $display("FAIL vec_hold_after_sweep: got %h expected f", o_vec);
        end
    endtask

    task automatic test_clean_sweep();
        sel = 2'd0;
        run_sweep(2, 0);
        n_checks++;
        if (busy_n !== 32) begin
            n_fail++; $display("FAIL clean_busy_cycles: got %0d expected 32", busy_n);
        end
        n_checks++;
        if (done_n !== 1 || done_at !== 32) begin
            n_fail++; $display("FAIL clean_done_pulse: got count=%0d at=%0d expected count=1 at=32", done_n, done_at);
        end
        n_checks++;
        if (seq_bad !== 0) begin
            n_fail++; $display("FAIL clean_vector_sequence: got %0d bad samples expected 0", seq_bad);
        end
        n_checks++;
        if ({o_cnt, o_seen, o_fi} !== 10'd0) begin
            n_fail++; $display("FAIL clean_errors_cleared: got cnt=%0d seen=%b fidx=%h expected 0/0/0", o_cnt, o_seen, o_fi);
        end
    endtask

    task automatic test_saturate();
        sel = 2'd1; fault = 2;
        run_sweep(2, 0);
        n_checks++;
        if (o_cnt !== 5'd7) begin
            n_fail++; $display("FAIL sat_err_cnt: got %0d expected 7", o_cnt);
        end
        n_checks++;
        if (o_seen !== 1'b1 || o_fi !== 4'h0) begin
            n_fail++; $display("FAIL sat_first_idx: got seen=%b fidx=%h expected seen=1 fidx=0", o_seen, o_fi);
        end
        sel = 2'd0;
    endtask

    task automatic test_start_ignored();
        sel = 2'd0;
        run_sweep(2, 1);
        n_checks++;
        if (busy_n !== 32 || seq_bad !== 0) begin
            n_fail++; $display("FAIL ignored_start_sweep: got busy=%0d bad=%0d expected busy=32 bad=0", busy_n, seq_bad);
        end
        n_checks++;
        if (done_n !== 1) begin
            n_fail++; $display("FAIL ignored_start_done_count: got %0d expected 1", done_n);
        end
    endtask

    task automatic test_p_sampling();
        sel = 2'd0;
        run_sweep(2, 2);
        n_checks++;
        if (o_cnt !== 5'd0 || o_seen !== 1'b0) begin
            n_fail++; $display("FAIL glitch_between_samples: got cnt=%0d seen=%b expected 0/0", o_cnt, o_seen);
        end
    endtask

    task automatic test_mid_reset();
        bit reached = 1'b0;
        bit done_hit = 1'b0;
        sel = 2'd0; fault = 2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 60 && !reached; k++) begin
            if (o_vec == 4'd5) reached = 1'b1;
            else begin @(posedge clk); #1; end
        end
        n_checks++;
        if (!reached) begin
            n_fail++; $display("FAIL mid_reset_reach_idx5: got vec=%h expected 5", o_vec);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o_busy, o_done, o_vec, o_cnt, o_seen, o_fi} !== 16'd0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got busy=%b done=%b vec=%h cnt=%0d seen=%b fidx=%h expected all 0",
                     o_busy, o_done, o_vec, o_cnt, o_seen, o_fi);
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (o_done) done_hit = 1'b1;
        end
        fault = 0;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (o_done || o_busy) done_hit = 1'b1;
        end
        n_checks++;
        if (done_hit) begin
            n_fail++; $display("FAIL mid_reset_no_done: got activity=1 expected 0");
        end
        run_sweep(2, 0);
        n_checks++;
        if (busy_n !== 32 || done_n !== 1 || seq_bad !== 0 || o_cnt !== 5'd0) begin
            n_fail++; $display("FAIL post_reset_sweep: got busy=%0d done=%0d bad=%0d cnt=%0d expected 32/1/0/0",
                               busy_n, done_n, seq_bad, o_cnt);
        end
    endtask

    task automatic test_hold_one();
        sel = 2'd2;
        run_sweep(1, 0);
        n_checks++;
        if (busy_n !== 16 || seq_bad !== 0) begin
            n_fail++; $display("FAIL hold1_busy: got busy=%0d bad=%0d expected busy=16 bad=0", busy_n, seq_bad);
        end
        n_checks++;
        if (done_n !== 1 || done_at !== 16) begin
            n_fail++; $display("FAIL hold1_done: got count=%0d at=%0d expected count=1 at=16", done_n, done_at);
        end
        n_checks++;
        if (o_cnt !== 5'd0) begin
            n_fail++; $display("FAIL hold1_err_cnt: got %0d expected 0", o_cnt);
        end
        sel = 2'd0;
    endtask

    task automatic test_start_held();
        logic busy_at_done, busy_after;
        sel = 2'd2;
        start = 1'b1;
        @(posedge clk); #1;
        busy_at_done = 1'b1; busy_after = 1'b0;
        for (int k = 0; k <= 18; k++) begin
            if (k == 16) busy_at_done = o_busy | ~o_done;
            if (k == 18) busy_after = o_busy;
            @(posedge clk); #1;
        end
        start = 1'b0;
        n_checks++;
        if (busy_at_done !== 1'b0 || busy_after !== 1'b1) begin
            n_fail++; $display("FAIL held_start_retrigger: got done_cycle_busy_or_nodone=%b busy_after=%b expected 0/1",
                               busy_at_done, busy_after);
        end
        repeat (24) @(posedge clk);
        #1;
        sel = 2'd0;
    endtask

    initial begin
        test_reset();
        test_p3_stuck();
        test_clean_sweep();
        test_saturate();
        test_start_ignored();
        test_p_sampling();
        test_mid_reset();
        test_hold_one();
        test_start_held();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
